// File: rtl/mi_spram_resp.sv
// mi_* burst responder on SPRAM: one word per cycle, first read strobe 2 cycles after accept.
// Backpressure: mi_ready only in IDLE; writes are consumed every WRITE cycle, reads never stall.
module mi_spram_resp #(
  parameter int AW = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] mi_addr,
  input  logic [6:0]  mi_len,
  input  logic        mi_rw,
  input  logic        mi_valid,
  output logic        mi_ready,
  input  logic [31:0] mi_wdata,
  input  logic [3:0]  mi_wmsk,
  output logic        mi_wack,
  output logic        mi_wlast,
  output logic [31:0] mi_rdata,
  output logic        mi_rstb,
  output logic        mi_rlast
);

  localparam int NB = (AW == 15) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [6:0]    cnt;
  logic          last;
  logic          wr_en, rd_issue;
  logic          bank_sel, bank_q;
  logic          rstb_q, rlast_q;
  logic [31:0]   bank_dout [2];
  logic          unused_addr;

  assign last        = (cnt == 7'd0);
  assign unused_addr = ^mi_addr[23:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (mi_valid) begin
          cnt  <= mi_len;
          addr <= mi_addr[AW-1:0];
        end
      end else begin
        cnt  <= cnt - 7'd1;
        addr <= addr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mi_valid) state_nxt = mi_rw ? READ : WRITE;
      READ:    if (last) state_nxt = IDLE;
      WRITE:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mi_ready = 1'b0;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    mi_wack  = 1'b0;
    mi_wlast = 1'b0;
    if (!rst) begin
      mi_ready = (state == IDLE);
      wr_en    = (state == WRITE);
      rd_issue = (state == READ);
      mi_wack  = wr_en;
      mi_wlast = wr_en & last;
    end
  end

  // Strobes are also gated by rst so a read issued just before reset never surfaces.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstb_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      rstb_q  <= rd_issue;
      rlast_q <= rd_issue & last;
      if (rd_issue) bank_q <= bank_sel;
    end
  end

  assign mi_rstb  = rstb_q & ~rst;
  assign mi_rlast = rlast_q & ~rst;
  assign mi_rdata = bank_dout[bank_q];

  generate
    if (AW == 15) begin : g_bank2
      assign bank_sel = addr[AW-1];
    end else begin : g_bank1
      assign bank_sel = 1'b0;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
      if (b < NB) begin : g_on
        localparam logic BSEL = (b == 1);
        logic we;
        assign we = wr_en & (bank_sel == BSEL);

        mi_spram_resp_ram u_lo (
          .clk        (clk),
          .address    (addr[13:0]),
          .datain     (mi_wdata[15:0]),
          .maskwren   ({~mi_wmsk[1], ~mi_wmsk[1], ~mi_wmsk[0], ~mi_wmsk[0]}),
          .wren       (we),
          .chipselect (1'b1),
          .standby    (1'b0),
          .sleep      (1'b0),
          .poweroff   (1'b1),
          .dataout    (bank_dout[b][15:0])
        );

        mi_spram_resp_ram u_hi (
          .clk        (clk),
          .address    (addr[13:0]),
          .datain     (mi_wdata[31:16]),
          .maskwren   ({~mi_wmsk[3], ~mi_wmsk[3], ~mi_wmsk[2], ~mi_wmsk[2]}),
          .wren       (we),
          .chipselect (1'b1),
          .standby    (1'b0),
          .sleep      (1'b0),
          .poweroff   (1'b1),
          .dataout    (bank_dout[b][31:16])
        );
      end else begin : g_off
        assign bank_dout[b] = '0;
      end
    end
  endgenerate

endmodule

// Behavioural equivalent of one SB_SPRAM256KA (16K x 16, nibble write mask, sync read).
// One cycle read latency; no backpressure.
module mi_spram_resp_ram (
  input  logic        clk,
  input  logic [13:0] address,
  input  logic [15:0] datain,
  input  logic [3:0]  maskwren,
  input  logic        wren,
  input  logic        chipselect,
  input  logic        standby,
  input  logic        sleep,
  input  logic        poweroff,
  output logic [15:0] dataout
);

  logic [15:0] mem [16384];
  logic        en;

  assign en = chipselect & ~standby & ~sleep & poweroff;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wren) begin
        for (int n = 0; n < 4; n++) begin
          if (maskwren[n]) mem[address][4*n +: 4] <= datain[4*n +: 4];
        end
      end else begin
        dataout <= mem[address];
      end
    end
  end

endmodule
